// File: rtl/ov7670_pixel_capture_if.sv
// Pixel stream interface between the OV7670 capture block and downstream logic.
// master drives the pixel; slave returns tready.
interface ov7670_pixel_capture_if;
    logic [15:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tuser;
    logic        tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/ov7670_pixel_capture.sv
// OV7670 byte-pair capture with frame geometry checks and an output skid FIFO.
// Optional macro OV_CAPTURE_TEST_PATTERN_EN adds tp_sel and a coordinate test pattern.
module ov7670_pixel_capture #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset_,
    input  logic                          cap_en,
`ifdef OV_CAPTURE_TEST_PATTERN_EN
    input  logic                          tp_sel,
`endif
    input  logic                          cam_pclk,
    input  logic                          cam_href,
    input  logic                          cam_vsync,
    input  logic [7:0]                    cam_d,
    ov7670_pixel_capture_if.master        m,
    output logic [7:0]                    frame_cnt,
    output logic                          geom_err,
    output logic                          ovf_err,
    input  logic                          err_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] H_CNT = 16'(H_ACTIVE);
    localparam logic [15:0] V_CNT = 16'(V_ACTIVE);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_LINE = 2'd1;
    localparam logic [1:0] LINE      = 2'd2;
    localparam logic [1:0] FRAME_END = 2'd3;

    logic [2:0] pclk_sr, href_sr, vsync_sr;
    logic [7:0] d_s1, d_s2;

    // NOTE: non-blocking assignments so every stage samples last cycle's value
    always_ff @(posedge clk or posedge reset_) begin
        if (reset_) begin
            pclk_sr  <= '0;
            href_sr  <= '0;
            vsync_sr <= '0;
            d_s1     <= '0;
            d_s2     <= '0;
        end else begin
            pclk_sr  <= {pclk_sr[1:0], cam_pclk};
            href_sr  <= {href_sr[1:0], cam_href};
            vsync_sr <= {vsync_sr[1:0], cam_vsync};
            d_s1     <= cam_d;
            d_s2     <= d_s1;
        end
    end

    logic pclk_rise, href_s2, href_fall, vsync_rise, vsync_fall;
    assign pclk_rise  = pclk_sr[1] & ~pclk_sr[2];
    assign href_s2    = href_sr[1];
    assign href_fall  = href_sr[2] & ~href_sr[1];
    assign vsync_rise = vsync_sr[1] & ~vsync_sr[2];
    assign vsync_fall = vsync_sr[2] & ~vsync_sr[1];

    logic [1:0]  state;
    logic        phase;
    logic [7:0]  hi_byte;
    logic [15:0] pixel_x, line_y;
    logic        sof_pending;
    logic        stage_valid, stage_tuser;
    logic [15:0] stage_data;
`ifdef OV_CAPTURE_TEST_PATTERN_EN
    logic        tp_on;
`endif

    logic        byte_in, px_form, line_end, abort, push;
    logic [17:0] push_word;
    logic [15:0] new_pixel;

    // NOTE: every output gets a default first so no path can infer a latch
    always_comb begin
        byte_in   = pclk_rise && href_s2;
        abort     = (state == LINE) && vsync_rise;
        line_end  = (state == LINE) && href_fall && !vsync_rise;
        px_form   = (state == LINE) && byte_in && phase && !vsync_rise;
        push      = stage_valid && (px_form || line_end || abort);
        push_word = {stage_tuser, line_end || abort, stage_data};
        new_pixel = {hi_byte, d_s2};
`ifdef OV_CAPTURE_TEST_PATTERN_EN
        if (tp_on)
            new_pixel = {pixel_x[7:0], line_y[7:0]};
`endif
    end

    // The staged pixel is only released once we know whether it ends the line.
    always_ff @(posedge clk or posedge reset_) begin
        if (reset_) begin
            state       <= IDLE;
            phase       <= 1'b0;
            hi_byte     <= '0;
            pixel_x     <= '0;
            line_y      <= '0;
            sof_pending <= 1'b0;
            stage_valid <= 1'b0;
            stage_tuser <= 1'b0;
            stage_data  <= '0;
            frame_cnt   <= '0;
            geom_err    <= 1'b0;
`ifdef OV_CAPTURE_TEST_PATTERN_EN
            tp_on       <= 1'b0;
`endif
        end else begin
            if (err_clr)
                geom_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cap_en && vsync_fall) begin
                        state       <= WAIT_LINE;
                        phase       <= 1'b0;
                        pixel_x     <= '0;
                        line_y      <= '0;
                        sof_pending <= 1'b1;
                        stage_valid <= 1'b0;
`ifdef OV_CAPTURE_TEST_PATTERN_EN
                        tp_on       <= tp_sel;
`endif
                    end
                end
                WAIT_LINE: begin
                    if (vsync_rise) begin
                        state <= FRAME_END;
                    end else if (byte_in) begin
                        hi_byte <= d_s2;
                        phase   <= 1'b1;
                        state   <= LINE;
                    end
                end
                LINE: begin
                    if (abort) begin
                        stage_valid <= 1'b0;
                        geom_err    <= 1'b1;
                        state       <= FRAME_END;
                    end else if (line_end) begin
                        stage_valid <= 1'b0;
                        if (phase || pixel_x != H_CNT)
                            geom_err <= 1'b1;
                        line_y  <= line_y + 16'd1;
                        pixel_x <= '0;
                        phase   <= 1'b0;
                        state   <= WAIT_LINE;
                    end else if (byte_in) begin
                        if (!phase) begin
                            hi_byte <= d_s2;
                            phase   <= 1'b1;
                        end else begin
                            stage_valid <= 1'b1;
                            stage_data  <= new_pixel;
                            stage_tuser <= sof_pending;
                            sof_pending <= 1'b0;
                            pixel_x     <= pixel_x + 16'd1;
                            phase       <= 1'b0;
                        end
                    end
                end
                FRAME_END: begin
                    if (line_y != V_CNT)
                        geom_err <= 1'b1;
                    frame_cnt <= frame_cnt + 8'd1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [17:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, empty, pop, wr_en;
    logic [17:0] head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && m.tready;
    assign wr_en = push && (!full || pop);

    // NOTE: the storage array has no reset; the pointers alone define what is valid
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= push_word;
    end

    always_ff @(posedge clk or posedge reset_) begin
        if (reset_) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (err_clr)
                ovf_err <= 1'b0;
            if (push && !wr_en)
                ovf_err <= 1'b1;
            if (wr_en)
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (pop)
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    assign head     = mem[rd_ptr[AW-1:0]];
    assign m.tvalid = !empty;
    assign m.tdata  = empty ? 16'd0 : head[15:0];
    assign m.tlast  = !empty && head[16];
    assign m.tuser  = !empty && head[17];
endmodule
